conv_top_system: RTL and testbench
==================================

# conv_top_system

Streaming 2-D convolution engine for one layer, no on-chip feature-map or weight storage. The host streams one activation word and one weight word per step. The block computes a 16-lane dot product (MEM_BW/IO_DATA_WIDTH lanes) and accumulates it. It emits one saturated 8-bit output per output pixel and output channel. It is the top level instantiated by the layer testbench (interface `intf`, stimulus `testprogram`).

## Interface
- IO_DATA_WIDTH, 8: activation, weight and output element width (signed).
- ACCUMULATION_WIDTH, 32: accumulator width (signed).
- FEATURE_MAP_WIDTH, 56: output columns X.
- FEATURE_MAP_HEIGHT, 56: output rows Y.
- INPUT_NB_CHANNELS, 64: input channels CI; must be a multiple of LANES.
- OUTPUT_NB_CHANNELS, 64: output channels CO.
- KERNEL_SIZE, 3: kernel side K.
- MEM_BW, 128: stream word width; LANES = MEM_BW/IO_DATA_WIDTH (16).
- ADDR_WIDTH_ACT, 14 / ADDR_WIDTH_WEIGHTS, 12: reserved, unused at this level.
- Ports:
  - clk  in  1  sole clock, rising edge.
  - arst_n_in  in  1  asynchronous, active-high reset (asserted = 1).
  - activations_input  in  MEM_BW  lane i = bits [8i+7:8i], signed activation of input channel cb*LANES+i.
  - weights_input  in  MEM_BW  lane i = signed weight for (co, cb*LANES+i, ky, kx).
  - activations_valid / weights_valid  in  1  host data valid.
  - activations_ready / weights_ready  out  1  block accepts data (always equal).
  - out  out  IO_DATA_WIDTH  signed result.
  - output_valid  out  1  out valid, single-cycle pulse per result.
  - start  in  1  launch a layer.
  - running  out  1  layer in progress.

## Operation
- States: IDLE, RUN.
  - IDLE → RUN on start=1.
  - RUN → IDLE after the final step of the layer.
  - start is ignored in RUN.
- Loop nest, outer to inner: y in [0,Y), x in [0,X), co in [0,CO), ky in [0,K), kx in [0,K), cb in [0,CI/LANES).
- Steps per output: S = K*K*CI/LANES (36 at defaults).
- Step fires when ready=1, activations_valid=1 and weights_valid=1 in the same cycle. Both words are consumed together.
- A step with only one valid does nothing. The host holds its data until the step fires.
- Padding is host-side: the host sends zero activations for out-of-bounds taps. The block does no bounds checks.
- dot = sum over the 16 lanes of signed 8x8 products, sign-extended to ACCUMULATION_WIDTH.
- Accumulator arithmetic wraps modulo 2^ACCUMULATION_WIDTH.
- First step of an output: acc <= dot (prior value discarded).
- Other steps: acc <= acc + dot.
- Last step (kx=K-1, ky=K-1, cb=last):
  - result = acc + dot, saturated to [-128, 127], registered into out.
  - output_valid pulses for one cycle.
- Output order follows the loop nest: y, x, co.
- Counters advance only on fired steps.

## Timing
- Reset (asynchronous, immediate): state IDLE, all counters 0, acc 0, out 0, output_valid 0, running 0, both readies 0.
- Reset mid-layer aborts the layer. No output is produced for the partial pixel.
- start sampled high in IDLE → running=1 and readies=1 from the next cycle.
- Ready stays 1 for every RUN cycle. Throughput is one step per cycle; the block never stalls.
- Result latency: out and output_valid are valid the cycle after the last step fires. out holds its value until the next result.
- output_valid is 0 in all other cycles.
- Final step of the layer:
  - running and readies drop to 0 in the next cycle, the same cycle output_valid pulses.
  - A new start is accepted from that cycle on.
- start and the first step cannot coincide: readies are 0 in the cycle start is sampled.
- Data path: 16 multipliers and an adder tree into the accumulator, all within one cycle (CLK_PERIOD=2 target). The multipliers and adders use the team adder/multiplier modules.

## Test plan
Small configuration for all scenarios: X=Y=2, CI=16, CO=2, K=3, so S=9 and 8 outputs per layer.

- All activations 1, all weights 1 → each step dot=16, total 144 → out=127 (saturated), 8 output_valid pulses, running then drops.
- Activation lane0=5, weight lane0=1, all other lanes 0 → out=45 for each output.
- Activations -2, weights 3 on all lanes → -864 → out=-128.
- Mixed-sign per-pixel values checked against a reference model, including values summing exactly to 127 and -128 (no saturation).
- Randomly deasserted activations_valid / weights_valid, independently → fires only when both are high; results identical to the back-to-back run.
- Assert arst_n_in mid-pixel → all outputs 0 immediately. start pulsed while running is ignored. Fresh start after reset gives correct results from pixel (0,0) co 0.

Source files
------------

// File: rtl/conv_top_system.sv
// Streaming single-layer convolution engine: one activation/weight word pair per step,
// a LANES-wide signed dot product accumulated per output, saturated to IO_DATA_WIDTH.

module conv_signed_mult #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] prod
);
    assign prod = a * b;
endmodule

module conv_signed_adder #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

// state | meaning
// IDLE  | waiting for start, readies low
// RUN   | streaming steps, one per cycle when both valids are high
module conv_top_system #(
    parameter int IO_DATA_WIDTH      = 8,
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int FEATURE_MAP_WIDTH  = 56,
    parameter int FEATURE_MAP_HEIGHT = 56,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3,
    parameter int MEM_BW             = 128,
    parameter int ADDR_WIDTH_ACT     = 14,
    parameter int ADDR_WIDTH_WEIGHTS = 12
) (
    input  logic                            clk,
    input  logic                            arst_n_in,
    input  logic [MEM_BW-1:0]               activations_input,
    input  logic [MEM_BW-1:0]               weights_input,
    input  logic                            activations_valid,
    input  logic                            weights_valid,
    output logic                            activations_ready,
    output logic                            weights_ready,
    output logic signed [IO_DATA_WIDTH-1:0] out,
    output logic                            output_valid,
    input  logic                            start,
    output logic                            running
);
    localparam int IO     = IO_DATA_WIDTH;
    localparam int ACC    = ACCUMULATION_WIDTH;
    localparam int LANES  = MEM_BW / IO_DATA_WIDTH;
    localparam int LEVELS = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int CBLKS  = INPUT_NB_CHANNELS / LANES;
    localparam int STEPS  = KERNEL_SIZE * KERNEL_SIZE * CBLKS;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int STEP_W = cnt_w(STEPS);
    localparam int CO_W   = cnt_w(OUTPUT_NB_CHANNELS);
    localparam int X_W    = cnt_w(FEATURE_MAP_WIDTH);
    localparam int Y_W    = cnt_w(FEATURE_MAP_HEIGHT);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [CO_W-1:0]   CO_LAST   = CO_W'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(FEATURE_MAP_WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(FEATURE_MAP_HEIGHT - 1);

    // Configuration sanity, caught at elaboration rather than as silent misbehaviour.
    if ((INPUT_NB_CHANNELS % LANES) != 0 || (1 << LEVELS) != LANES) begin : g_bad_lanes
        $error("conv_top_system: channel count / lane count configuration unsupported");
    end
    if (ADDR_WIDTH_ACT < 1 || ADDR_WIDTH_WEIGHTS < 1 || ACC <= 2 * IO) begin : g_bad_widths
        $error("conv_top_system: width parameters out of range");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state;
    logic                    ready_q;
    logic [STEP_W-1:0]       step_cnt;
    logic [CO_W-1:0]         co_cnt;
    logic [X_W-1:0]          x_cnt;
    logic [Y_W-1:0]          y_cnt;
    logic signed [ACC-1:0]   acc;
    logic signed [ACC-1:0]   acc_base;
    logic signed [ACC-1:0]   acc_sum;
    logic signed [ACC-1:0]   dot;
    logic                    fire;
    logic                    first_step;
    logic                    last_step;

    assign activations_ready = ready_q;
    assign weights_ready     = ready_q;

    assign fire       = ready_q & activations_valid & weights_valid;
    assign first_step = (step_cnt == STEP_LAST);
    assign last_step  = (step_cnt == '0);

    // Level 0 holds the sign-extended lane products; each level halves the node count.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = LANES >> l;
        logic signed [ACC-1:0] node [N];
        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < N; j++) begin : g_lane
                logic signed [IO-1:0]   a_lane;
                logic signed [IO-1:0]   w_lane;
                logic signed [2*IO-1:0] prod;
                assign a_lane = activations_input[j*IO +: IO];
                assign w_lane = weights_input[j*IO +: IO];
                conv_signed_mult #(.WIDTH(IO)) u_mult (
                    .a    (a_lane),
                    .b    (w_lane),
                    .prod (prod)
                );
                assign node[j] = {{(ACC-2*IO){prod[2*IO-1]}}, prod};
            end
        end else begin : g_sum
            for (genvar j = 0; j < N; j++) begin : g_node
                conv_signed_adder #(.WIDTH(ACC)) u_add (
                    .a   (g_lvl[l-1].node[2*j]),
                    .b   (g_lvl[l-1].node[2*j+1]),
                    .sum (node[j])
                );
            end
        end
    end

    assign dot = g_lvl[LEVELS].node[0];

    // The first step of an output starts from zero so stale accumulator contents never leak.
    assign acc_base = first_step ? '0 : acc;

    conv_signed_adder #(.WIDTH(ACC)) u_acc_add (
        .a   (acc_base),
        .b   (dot),
        .sum (acc_sum)
    );

    function automatic logic signed [IO-1:0] saturate(input logic signed [ACC-1:0] v);
        logic signed [ACC-1:0] hi;
        logic signed [ACC-1:0] lo;
        hi = {{(ACC-IO+1){1'b0}}, {(IO-1){1'b1}}};
        lo = {{(ACC-IO+1){1'b1}}, {(IO-1){1'b0}}};
        if (v > hi) begin
            return {1'b0, {(IO-1){1'b1}}};
        end else if (v < lo) begin
            return {1'b1, {(IO-1){1'b0}}};
        end else begin
            return v[IO-1:0];
        end
    endfunction

    always_ff @(posedge clk or posedge arst_n_in) begin
        if (arst_n_in) begin
            state        <= IDLE;
            running      <= 1'b0;
            ready_q      <= 1'b0;
            step_cnt     <= '0;
            co_cnt       <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            acc          <= '0;
            out          <= '0;
            output_valid <= 1'b0;
        end else begin
            output_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        running  <= 1'b1;
                        ready_q  <= 1'b1;
                        step_cnt <= STEP_LAST;
                        co_cnt   <= CO_LAST;
                        x_cnt    <= X_LAST;
                        y_cnt    <= Y_LAST;
                    end
                end
                RUN: begin
                    if (fire) begin
                        acc <= acc_sum;
                        if (last_step) begin
                            out          <= saturate(acc_sum);
                            output_valid <= 1'b1;
                            step_cnt     <= STEP_LAST;
                            if (co_cnt == '0) begin
                                co_cnt <= CO_LAST;
                                if (x_cnt == '0) begin
                                    x_cnt <= X_LAST;
                                    if (y_cnt == '0) begin
                                        y_cnt   <= Y_LAST;
                                        state   <= IDLE;
                                        running <= 1'b0;
                                        ready_q <= 1'b0;
                                    end else begin
                                        y_cnt <= y_cnt - 1'b1;
                                    end
                                end else begin
                                    x_cnt <= x_cnt - 1'b1;
                                end
                            end else begin
                                co_cnt <= co_cnt - 1'b1;
                            end
                        end else begin
                            step_cnt <= step_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_top_system.sv
// Directed bench for conv_top_system in a small configuration (X=Y=2, CI=16, CO=2, K=3).
// Expected outputs are hand-computed per stimulus pattern.

module tb_conv_top_system;
    localparam int MBW   = 128;
    localparam int LANES = 16;
    localparam int S     = 9;
    localparam int NOUT  = 8;
    localparam int NSTEP = NOUT * S;

    logic              clk = 1'b0;
    logic              rst;
    logic [MBW-1:0]    act_in;
    logic [MBW-1:0]    wt_in;
    logic              av;
    logic              wv;
    logic              act_ready;
    logic              wt_ready;
    logic signed [7:0] dout;
    logic              ov;
    logic              start;
    logic              running;

    int n_checks = 0;
    int n_fail   = 0;
    int got[$];

    always #5 clk = ~clk;

    conv_top_system #(
        .IO_DATA_WIDTH      (8),
        .ACCUMULATION_WIDTH (32),
        .FEATURE_MAP_WIDTH  (2),
        .FEATURE_MAP_HEIGHT (2),
        .INPUT_NB_CHANNELS  (16),
        .OUTPUT_NB_CHANNELS (2),
        .KERNEL_SIZE        (3),
        .MEM_BW             (MBW),
        .ADDR_WIDTH_ACT     (14),
        .ADDR_WIDTH_WEIGHTS (12)
    ) dut (
        .clk               (clk),
        .arst_n_in         (rst),
        .activations_input (act_in),
        .weights_input     (wt_in),
        .activations_valid (av),
        .weights_valid     (wv),
        .activations_ready (act_ready),
        .weights_ready     (wt_ready),
        .out               (dout),
        .output_valid      (ov),
        .start             (start),
        .running           (running)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ov === 1'b1) got.push_back(int'(dout));
    end

    // Pattern 3: lane0 carries the per-output value, lanes 1/2/15 cancel over a pixel.
    function automatic int mix_act(input int o, input int s);
        case (o)
            0:       return (s == 8) ? 15 : 14;
            1, 2:    return (s == 8) ? 16 : 14;
            3:       return (s == 8) ? -17 : -14;
            4, 5:    return (s == 8) ? 8 : 4;
            6:       return 100;
            default: return 0;
        endcase
    endfunction

    function automatic int mix_wt(input int o, input int s);
        case (o)
            1, 5:    return -1;
            6:       return (s % 2 == 1) ? -1 : 1;
            default: return 1;
        endcase
    endfunction

    function automatic logic [MBW-1:0] gen_word(input int pat, input int o, input int s, input bit is_wt);
        logic [MBW-1:0] w;
        w = '0;
        case (pat)
            0: for (int l = 0; l < LANES; l++) w[8*l +: 8] = 8'(1);
            1: w[7:0] = is_wt ? 8'(1) : 8'(5);
            2: for (int l = 0; l < LANES; l++) w[8*l +: 8] = is_wt ? 8'(3) : 8'(-2);
            default: begin
                w[7:0]     = is_wt ? 8'(mix_wt(o, s)) : 8'(mix_act(o, s));
                w[15:8]    = is_wt ? 8'(-1) : 8'(7);
                w[23:16]   = is_wt ? 8'(1)  : 8'(7);
                w[127:120] = is_wt ? 8'(s - 4) : 8'(-3);
            end
        endcase
        return w;
    endfunction

    function automatic int exp_out(input int pat, input int o);
        case (pat)
            0: return 127;
            1: return 45;
            2: return -128;
            default: begin
                case (o)
                    0, 2:    return 127;
                    1, 3:    return -128;
                    4:       return 40;
                    5:       return -40;
                    6:       return 100;
                    default: return 0;
                endcase
            end
        endcase
    endfunction

    task automatic start_layer();
        @(negedge clk);
        start = 1'b1;
        check_val("ready_while_start_sampled", int'(act_ready), 0);
        @(negedge clk);
        start = 1'b0;
        check_val("running_after_start", int'(running), 1);
        check_val("ready_after_start", int'(act_ready & wt_ready), 1);
    endtask

    task automatic run_steps(input int pat, input int nsteps, input bit rnd, input bit poke_start);
        int step;
        int cyc;
        bit fire;
        step = 0;
        cyc  = 0;
        while (step < nsteps && cyc < 4000) begin
            @(negedge clk);
            act_in = gen_word(pat, step / S, step % S, 1'b0);
            wt_in  = gen_word(pat, step / S, step % S, 1'b1);
            av     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wv     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start  = poke_start && (step == 30);
            fire   = act_ready && av && wv;
            @(posedge clk);
            if (fire) step++;
            cyc++;
        end
        if (step < nsteps) check_val("step_budget", step, nsteps);
        #1;
        av    = 1'b0;
        wv    = 1'b0;
        start = 1'b0;
    endtask

    task automatic finish_layer(input int pat);
        @(negedge clk);
        check_val("last_output_valid", int'(ov), 1);
        check_val("running_dropped", int'(running), 0);
        check_val("ready_dropped", int'(act_ready | wt_ready), 0);
        repeat (3) @(negedge clk);
        check_val("output_count", got.size(), NOUT);
        for (int i = 0; i < NOUT; i++) begin
            check_val($sformatf("out_p%0d_o%0d", pat, i), (i < got.size()) ? got[i] : -999, exp_out(pat, i));
        end
        got.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        act_in = '0;
        wt_in  = '0;
        av     = 1'b0;
        wv     = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_out", int'(dout), 0);
        check_val("reset_valid", int'(ov), 0);
        check_val("reset_running", int'(running), 0);
        check_val("reset_ready", int'(act_ready | wt_ready), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_ready", int'(act_ready | wt_ready), 0);

        for (int p = 0; p < 4; p++) begin
            start_layer();
            run_steps(p, NSTEP, 1'b0, 1'b0);
            finish_layer(p);
        end

        start_layer();
        run_steps(3, NSTEP, 1'b1, 1'b1);
        finish_layer(3);

        start_layer();
        run_steps(0, 40, 1'b0, 1'b0);
        @(negedge clk);
        check_val("outputs_before_reset", got.size(), 4);
        check_val("out_before_reset", int'(dout), 127);
        #1 rst = 1'b1;
        #1;
        check_val("async_reset_out", int'(dout), 0);
        check_val("async_reset_running", int'(running), 0);
        check_val("async_reset_ready", int'(act_ready | wt_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_val("no_output_after_reset", got.size(), 4);
        got.delete();

        start_layer();
        run_steps(3, NSTEP, 1'b0, 1'b0);
        finish_layer(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
